// File: rtl/ks_pkg.sv
// Shared types and elaboration helpers for the Kogge-Stone prefix adder.
package ks_pkg;

    // Per-bit generate/propagate pair carried through the prefix network.
    typedef struct packed {
        logic g;
        logic p;
    } ks_gp_t;

    // Number of set bits; the pipeline latency is 1 + popcount(PIPE_MASK).
    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 32'sd0;
        for (int k = 0; k < 32; k++) begin
            if (v[k]) begin
                n = n + 32'sd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // True when v is a positive power of two.
    function automatic bit is_pow2(input int v);
        return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: black cells at distance DIST, gray cells that
// fold the carry-in into bits already spanning down to bit 0, plus an optional
// pipeline register that advances on the shared stall enable.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIST   = 1,
    parameter int SIDE_W = 34,
    parameter bit REG    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  adv_i,
    input  logic                  valid_i,
    input  logic                  cin_i,
    input  ks_gp_t [WIDTH-1:0]    gp_i,
    input  logic   [SIDE_W-1:0]   side_i,
    output logic                  valid_o,
    output logic                  cin_o,
    output ks_gp_t [WIDTH-1:0]    gp_o,
    output logic   [SIDE_W-1:0]   side_o
);

    ks_gp_t [WIDTH-1:0] gp_d;

    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
        if (j >= DIST) begin : g_black
            assign gp_d[j] = {gp_i[j].g | (gp_i[j].p & gp_i[j-DIST].g),
                              gp_i[j].p & gp_i[j-DIST].p};
        end else begin : g_gray
            // Group already reaches bit 0: absorb cin, propagate is then dead,
            // so absorbing again at later levels is harmless.
            assign gp_d[j] = {gp_i[j].g | (gp_i[j].p & cin_i), 1'b0};
        end
    end

    if (REG) begin : g_reg
        logic               valid_q;
        logic               cin_q;
        ks_gp_t [WIDTH-1:0] gp_q;
        logic [SIDE_W-1:0]  side_q;

        // Level register: everything moves together only when the pipe advances.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                cin_q   <= 1'b0;
                gp_q    <= '0;
                side_q  <= '0;
            end else if (adv_i) begin
                valid_q <= valid_i;
                cin_q   <= cin_i;
                gp_q    <= gp_d;
                side_q  <= side_i;
            end
        end

        assign valid_o = valid_q;
        assign cin_o   = cin_q;
        assign gp_o    = gp_q;
        assign side_o  = side_q;
    end else begin : g_comb
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i, adv_i};

        assign valid_o = valid_i;
        assign cin_o   = cin_i;
        assign gp_o    = gp_d;
        assign side_o  = side_i;
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready pipe.
// Latency is 1 (input stage) + one cycle per bit set in PIPE_MASK; the bit for
// the last level places the register after result formation.
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int                         WIDTH     = 32,
    parameter logic [$clog2(WIDTH)-1:0]   PIPE_MASK = {$clog2(WIDTH){1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS = $clog2(WIDTH);
    // Side band: {A msb, B' msb, original per-bit propagate}.
    localparam int SIDE_W = WIDTH + 2;

    if (!is_pow2(WIDTH) || (WIDTH < 4) || (WIDTH > 64)) begin : g_bad_width
        $error("ks_adder_pipe: WIDTH must be a power of two in 4..64");
    end

    logic adv;
    logic take;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign take     = in_valid && adv;

    logic [WIDTH-1:0]   b_eff;
    logic               cin_d;
    ks_gp_t [WIDTH-1:0] gp_d;
    logic [SIDE_W-1:0]  side_d;

    // Operand conditioning: subtract is A + ~B + 1, cin is forced to 1.
    always_comb begin
        b_eff  = in_sub ? ~in_b : in_b;
        cin_d  = in_sub ? 1'b1 : in_cin;
        gp_d   = '0;
        for (int j = 0; j < WIDTH; j++) begin
            gp_d[j].g = in_a[j] & b_eff[j];
            gp_d[j].p = in_a[j] ^ b_eff[j];
        end
        side_d = {in_a[WIDTH-1], b_eff[WIDTH-1], in_a ^ b_eff};
    end

    logic               in_valid_q;
    logic               in_cin_q;
    ks_gp_t [WIDTH-1:0] in_gp_q;
    logic [SIDE_W-1:0]  in_side_q;

    // Input stage: valid shifts on every advance; operands load only on a
    // transfer so bubbles leave the datapath untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_cin_q   <= 1'b0;
            in_gp_q    <= '0;
            in_side_q  <= '0;
        end else begin
            if (adv) begin
                in_valid_q <= in_valid;
            end
            if (take) begin
                in_cin_q  <= cin_d;
                in_gp_q   <= gp_d;
                in_side_q <= side_d;
            end
        end
    end

    logic               lv_valid [LEVELS+1];
    logic               lv_cin   [LEVELS+1];
    ks_gp_t [WIDTH-1:0] lv_gp    [LEVELS+1];
    logic [SIDE_W-1:0]  lv_side  [LEVELS+1];

    assign lv_valid[0] = in_valid_q;
    assign lv_cin[0]   = in_cin_q;
    assign lv_gp[0]    = in_gp_q;
    assign lv_side[0]  = in_side_q;

    for (genvar i = 0; i < LEVELS; i++) begin : g_level
        ks_prefix_level #(
            .WIDTH  (WIDTH),
            .DIST   (32'sd1 << i),
            .SIDE_W (SIDE_W),
            .REG    ((i == LEVELS - 1) ? 1'b0 : PIPE_MASK[i])
        ) u_level (
            .clk_i   (clk),
            .rst_i   (rst),
            .adv_i   (adv),
            .valid_i (lv_valid[i]),
            .cin_i   (lv_cin[i]),
            .gp_i    (lv_gp[i]),
            .side_i  (lv_side[i]),
            .valid_o (lv_valid[i+1]),
            .cin_o   (lv_cin[i+1]),
            .gp_o    (lv_gp[i+1]),
            .side_o  (lv_side[i+1])
        );
    end

    ks_gp_t [WIDTH-1:0] fin_gp;
    logic [SIDE_W-1:0]  fin_side;
    logic               fin_cin;
    logic [WIDTH-1:0]   carry;
    logic [WIDTH-1:0]   res_sum;
    logic               res_cout;
    logic               res_ovf;

    assign fin_gp   = lv_gp[LEVELS];
    assign fin_side = lv_side[LEVELS];
    assign fin_cin  = lv_cin[LEVELS];

    // Final carries (folding cin into any group not yet gray-absorbed),
    // then sum bits and flags.
    always_comb begin
        carry   = '0;
        res_sum = '0;
        for (int j = 0; j < WIDTH; j++) begin
            carry[j] = fin_gp[j].g | (fin_gp[j].p & fin_cin);
        end
        res_sum[0] = fin_side[0] ^ fin_cin;
        for (int j = 1; j < WIDTH; j++) begin
            res_sum[j] = fin_side[j] ^ carry[j-1];
        end
        res_cout = carry[WIDTH-1];
        res_ovf  = (fin_side[WIDTH+1] == fin_side[WIDTH]) &&
                   (res_sum[WIDTH-1] != fin_side[WIDTH+1]);
    end

    if (PIPE_MASK[LEVELS-1]) begin : g_out_reg
        logic             out_valid_q;
        logic [WIDTH-1:0] out_sum_q;
        logic             out_cout_q;
        logic             out_ovf_q;

        // Output register: holds the result stable while the consumer stalls.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_sum_q   <= '0;
                out_cout_q  <= 1'b0;
                out_ovf_q   <= 1'b0;
            end else if (adv) begin
                out_valid_q <= lv_valid[LEVELS];
                out_sum_q   <= res_sum;
                out_cout_q  <= res_cout;
                out_ovf_q   <= res_ovf;
            end
        end

        assign out_valid = out_valid_q;
        assign out_sum   = out_sum_q;
        assign out_cout  = out_cout_q;
        assign out_ovf   = out_ovf_q;
    end else begin : g_out_comb
        assign out_valid = lv_valid[LEVELS];
        assign out_sum   = res_sum;
        assign out_cout  = res_cout;
        assign out_ovf   = res_ovf;
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed bench for ks_adder_pipe: 8-bit fully piped, 32-bit unpiped, and
// four 4-bit instances covering every PIPE_MASK value.
module tb_ks_adder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, cout, sum} using ordinary arithmetic.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] msk, am, bb, s;
        logic [64:0] full;
        logic co, ov;
        msk  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = a & msk;
        bb   = (sub ? ~b : b) & msk;
        full = {1'b0, am} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : cin)};
        s    = full[63:0] & msk;
        co   = full[w];
        ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    // 8-bit, all levels registered (LAT=4)
    logic       v8 = 1'b0, irdy8, ov8, ordy8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0, co8, ovf8;
    logic [7:0] a8 = 8'd0, b8 = 8'd0, sum8;

    ks_adder_pipe #(.WIDTH(8), .PIPE_MASK(3'b111)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(irdy8), .in_a(a8), .in_b(b8),
        .in_cin(cin8), .in_sub(sub8), .out_valid(ov8), .out_ready(ordy8),
        .out_sum(sum8), .out_cout(co8), .out_ovf(ovf8));

    // 32-bit, no level registers (LAT=1)
    logic        v32 = 1'b0, irdy32, ov32, ordy32 = 1'b1, cin32 = 1'b0, sub32 = 1'b0, co32, ovf32;
    logic [31:0] a32 = 32'd0, b32 = 32'd0, sum32;

    ks_adder_pipe #(.WIDTH(32), .PIPE_MASK(5'b00000)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(irdy32), .in_a(a32), .in_b(b32),
        .in_cin(cin32), .in_sub(sub32), .out_valid(ov32), .out_ready(ordy32),
        .out_sum(sum32), .out_cout(co32), .out_ovf(ovf32));

    // 4-bit, one instance per PIPE_MASK value, shared stimulus
    logic       v4 = 1'b0, ordy4 = 1'b1, cin4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = 4'd0, b4 = 4'd0;
    logic       irdy4 [4];
    logic       ov4   [4];
    logic       co4   [4];
    logic       ovf4  [4];
    logic [3:0] sum4  [4];
    int         lat4  [4] = '{1, 2, 2, 3};

    for (genvar m = 0; m < 4; m++) begin : g_w4
        ks_adder_pipe #(.WIDTH(4), .PIPE_MASK(2'(m))) u_dut4 (
            .clk(clk), .rst(rst), .in_valid(v4), .in_ready(irdy4[m]), .in_a(a4), .in_b(b4),
            .in_cin(cin4), .in_sub(sub4), .out_valid(ov4[m]), .out_ready(ordy4),
            .out_sum(sum4[m]), .out_cout(co4[m]), .out_ovf(ovf4[m]));
    end

    // One 8-bit operation: valid must stay low for 3 cycles and appear on the 4th.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; v8 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            v8 = 1'b0;
            if (k < 4) check($sformatf("%s_early%0d", tag, k), 64'(ov8), 64'd0);
        end
        check($sformatf("%s_valid", tag), 64'(ov8), 64'd1);
        check($sformatf("%s_sum", tag), 64'(sum8), 64'(es));
        check($sformatf("%s_cout", tag), 64'(co8), 64'(ec));
        check($sformatf("%s_ovf", tag), 64'(ovf8), 64'(eo));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra [100];
        logic [31:0] rb [100];
        logic        rc [100];
        logic        rs [100];
        logic [65:0] e;
        logic [65:0] expq [$];
        int          sent, got, step, idx;
        logic        stall_prev;
        logic [7:0]  snap_sum;
        logic        snap_c, snap_o;

        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        check("rst8_valid", 64'(ov8), 64'd0);
        check("rst8_sum", 64'(sum8), 64'd0);
        check("rst8_cout", 64'(co8), 64'd0);
        check("rst8_ovf", 64'(ovf8), 64'd0);
        check("rst8_in_ready", 64'(irdy8), 64'd1);
        check("rst32_valid", 64'(ov32), 64'd0);
        check("rst32_sum", 64'(sum32), 64'd0);
        check("rst32_in_ready", 64'(irdy32), 64'd1);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("rst4_%0d_valid", m), 64'(ov4[m]), 64'd0);
            check($sformatf("rst4_%0d_sum", m), 64'(sum4[m]), 64'd0);
            check($sformatf("rst4_%0d_in_ready", m), 64'(irdy4[m]), 64'd1);
        end

        // ---------------- 8-bit directed, LAT=4 ----------------
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run8("sub_03_05", 8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("add_0f_01_c", 8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        run8("sub_cin_ign", 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

        // ---------------- 32-bit directed, LAT=1 ----------------
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; sub32 = 1'b0; v32 = 1'b1;
        tick();
        v32 = 1'b0;
        check("w32_wrap_valid", 64'(ov32), 64'd1);
        check("w32_wrap_sum", 64'(sum32), 64'd0);
        check("w32_wrap_cout", 64'(co32), 64'd1);
        check("w32_wrap_ovf", 64'(ovf32), 64'd0);
        tick();
        check("w32_bubble_valid", 64'(ov32), 64'd0);
        a32 = 32'h7FFF_FFFF; b32 = 32'h1; cin32 = 1'b0; v32 = 1'b1;
        tick();
        check("w32_ovf_sum", 64'(sum32), 64'h8000_0000);
        check("w32_ovf_flag", 64'(ovf32), 64'd1);
        check("w32_ovf_cout", 64'(co32), 64'd0);
        a32 = 32'h0; b32 = 32'h1; sub32 = 1'b1;
        tick();
        v32 = 1'b0; sub32 = 1'b0;
        check("w32_borrow_sum", 64'(sum32), 64'hFFFF_FFFF);
        check("w32_borrow_cout", 64'(co32), 64'd0);
        check("w32_borrow_ovf", 64'(ovf32), 64'd0);
        tick();

        // ---------------- 32-bit back-to-back random stream ----------------
        for (int c = 0; c <= 101; c++) begin
            if (c >= 1 && c <= 100) begin
                e = model(32, 64'(ra[c-1]), 64'(rb[c-1]), rc[c-1], rs[c-1]);
                check($sformatf("rnd%0d_valid", c - 1), 64'(ov32), 64'd1);
                check($sformatf("rnd%0d_sum", c - 1), 64'(sum32), e[63:0]);
                check($sformatf("rnd%0d_cout", c - 1), 64'(co32), 64'(e[64]));
                check($sformatf("rnd%0d_ovf", c - 1), 64'(ovf32), 64'(e[65]));
            end else if (c == 101) begin
                check("rnd_drain_valid", 64'(ov32), 64'd0);
            end
            if (c < 100) begin
                ra[c] = $urandom; rb[c] = $urandom;
                rc[c] = 1'($urandom_range(0, 1)); rs[c] = 1'($urandom_range(0, 1));
                a32 = ra[c]; b32 = rb[c]; cin32 = rc[c]; sub32 = rs[c]; v32 = 1'b1;
            end else begin
                v32 = 1'b0;
            end
            tick();
        end

        // ---------------- 8-bit backpressure ----------------
        sent = 0; got = 0; step = 0; stall_prev = 1'b0;
        snap_sum = 8'd0; snap_c = 1'b0; snap_o = 1'b0;
        while (got < 10 && step < 200) begin
            ordy8 = ((step % 3) == 0);
            v8    = (sent < 10);
            a8    = 8'(sent * 37 + 5);
            b8    = 8'(sent * 91 + 200);
            cin8  = sent[0];
            sub8  = sent[1];
            #1;
            if (stall_prev) begin
                check($sformatf("bp_hold_valid_s%0d", step), 64'(ov8), 64'd1);
                check($sformatf("bp_hold_sum_s%0d", step), 64'(sum8), 64'(snap_sum));
                check($sformatf("bp_hold_cout_s%0d", step), 64'(co8), 64'(snap_c));
                check($sformatf("bp_hold_ovf_s%0d", step), 64'(ovf8), 64'(snap_o));
            end
            if (ov8 && !ordy8) begin
                check($sformatf("bp_in_ready_s%0d", step), 64'(irdy8), 64'd0);
                stall_prev = 1'b1;
                snap_sum = sum8; snap_c = co8; snap_o = ovf8;
            end else begin
                stall_prev = 1'b0;
            end
            if (ov8 && ordy8) begin
                if (expq.size() == 0) begin
                    check($sformatf("bp_unexpected_s%0d", step), 64'(ov8), 64'd0);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("bp%0d_sum", got), 64'(sum8), 64'(e[7:0]));
                    check($sformatf("bp%0d_cout", got), 64'(co8), 64'(e[64]));
                    check($sformatf("bp%0d_ovf", got), 64'(ovf8), 64'(e[65]));
                    got++;
                end
            end
            if (v8 && irdy8) begin
                expq.push_back(model(8, 64'(a8), 64'(b8), cin8, sub8));
                sent++;
            end
            tick();
            step++;
        end
        check("bp_received", 64'(got), 64'd10);
        v8 = 1'b0; ordy8 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp_no_dup%0d", k), 64'(ov8), 64'd0);
            tick();
        end

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 3; k++) begin
            a8 = 8'(k * 50 + 17); b8 = 8'(k * 13 + 99); cin8 = 1'b1; sub8 = 1'b0; v8 = 1'b1;
            tick();
        end
        v8 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("mid_rst_valid%0d", k), 64'(ov8), 64'd0);
            check($sformatf("mid_rst_sum%0d", k), 64'(sum8), 64'd0);
            check($sformatf("mid_rst_cout%0d", k), 64'(co8), 64'd0);
            tick();
        end
        run8("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // ---------------- 4-bit exhaustive sweep, every mask ----------------
        for (int c = 0; c < 1024 + 4; c++) begin
            for (int m = 0; m < 4; m++) begin
                idx = c - lat4[m];
                if (idx >= 0 && idx < 1024) begin
                    e = model(4, 64'(idx[7:4]), 64'(idx[3:0]), idx[8], idx[9]);
                    check($sformatf("w4m%0d_v%0d_valid", m, idx), 64'(ov4[m]), 64'd1);
                    check($sformatf("w4m%0d_v%0d_sum", m, idx), 64'(sum4[m]), 64'(e[3:0]));
                    check($sformatf("w4m%0d_v%0d_cout", m, idx), 64'(co4[m]), 64'(e[64]));
                    check($sformatf("w4m%0d_v%0d_ovf", m, idx), 64'(ovf4[m]), 64'(e[65]));
                end else begin
                    check($sformatf("w4m%0d_c%0d_idle", m, c), 64'(ov4[m]), 64'd0);
                end
            end
            if (c < 1024) begin
                b4 = c[3:0]; a4 = c[7:4]; cin4 = c[8]; sub4 = c[9]; v4 = 1'b1;
            end else begin
                v4 = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready flow control.
- Next generation of the fixed 8-bit combinational prefix adder: any power-of-two WIDTH, selectable per-level pipeline registers, add/sub mode, carry and overflow flags.
- Sits in the arithmetic library as the standard high-throughput adder for datapaths and multiplier final-sum stages.

Parameters:
- WIDTH, 32, operand width; power of two, 4..64.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not overridable.
- PIPE_MASK, {LEVELS{1'b1}}, bit i set means a register follows prefix level i.
- LAT, 1+popcount(PIPE_MASK), cycles from input acceptance to output valid; derived.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in; ignored when in_sub=1
- in_sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out; for sub, 1 means no borrow
- out_ovf  out  1  signed overflow

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Reset: all stage valid bits cleared; out_valid=0, out_sum=0, out_cout=0, out_ovf=0; in_ready=1 in the first cycle after reset. Reset mid-operation discards all in-flight results; no partial output.
- Input stage (always registered): captures P=a^b', G=a&b', the effective cin, and the operand MSBs for overflow, where b' = in_sub ? ~in_b : in_b.
- Prefix levels i=0..LEVELS-1, distance 2^i:
  - Bits j >= 2^i: black cell (G,P combine).
  - Bits j < 2^i: gray cell absorbing cin; these become final carries.
  - Level output is registered if PIPE_MASK[i], combinational otherwise.
- The final level registers into the output stage when PIPE_MASK[LEVELS-1]=1. Otherwise sum, cout and ovf are formed combinationally from the last register.
- Result formation:
  - sum[0] = P0^cin; sum[j] = P[j]^C[j-1].
  - cout = C[WIDTH-1].
  - ovf = (A_msb==B'_msb) && (sum_msb!=A_msb).
- Flow control: global stall.
  - adv = !out_valid || out_ready; in_ready = adv.
  - Every pipeline register, including valid bits, loads only when adv=1.
  - Transfer occurs when in_valid && in_ready. A bubble (in_valid=0 while adv=1) shifts a 0 valid bit.
- Throughput and latency: one result per cycle with out_ready held high. Latency is exactly LAT cycles with no stall.
- Stall: while out_valid && !out_ready, out_sum, out_cout and out_ovf hold stable, and no stage changes.
- Simultaneous in_valid and out_ready while full: the output is consumed and the new input accepted in the same cycle.
- Operand wrap-around: sum is modulo 2^WIDTH; cout carries the lost bit.
- Generate-based structure, no behavioural '+' operator in the datapath.

Decomposition:
- Package ks_pkg:
  - Function popcount for LAT.
  - Localparam check: WIDTH is a power of two, else elaboration error.
  - Struct type ks_gp_t {g, p} for per-bit prefix signals.
- Sub-module ks_prefix_level (parameters WIDTH, DIST, REG):
  - One prefix level of black/gray cells plus an optional register.
  - Has its own valid bit and a shared adv enable, instantiated LEVELS times.

Test Plan:
- WIDTH=8, PIPE_MASK=3'b111, out_ready=1:
  - a=8'hFF, b=8'h01, cin=0 -> after 4 cycles sum=8'h00, cout=1, ovf=0.
- WIDTH=8, sub=1:
  - a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
  - a=8'h03, b=8'h05 -> sum=8'hFE, cout=0, ovf=0.
- WIDTH=32, PIPE_MASK=5'b00000 (LAT=1):
  - a=32'hFFFF_FFFF, b=0, cin=1 -> next cycle sum=0, cout=1.
  - Back-to-back stream of 100 random operands matches the reference model every cycle.
- Backpressure:
  - Stream 10 operands with out_ready toggling 1,0,0,1... -> no loss or duplication, order preserved.
  - Outputs stay stable during stall; in_ready=0 whenever out_valid && !out_ready.
- Reset mid-stream:
  - Assert rst for 1 cycle with 3 results in flight -> out_valid=0 next cycle and for LAT cycles unless new inputs are accepted.
  - Out_sum reads 0.
- Exhaustive WIDTH=4 sweep over all a, b, cin and sub with every PIPE_MASK value -> all results match the model; latency equals LAT for each mask.
